// File: rtl/pen_tracker_if.sv
// ============================================================================
//  Module   : pen_tracker_if
//  Purpose  : Camera-side sample strobe and pixel-buffer draw handshake
//             grouped for the pen_tracker block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pen_tracker_if;
  logic [9:0] cam_x;
  logic [9:0] cam_y;
  logic       cam_valid;
  logic [9:0] pen_x;
  logic [9:0] pen_y;
  logic       pen_down;
  logic       draw_valid;
  logic       draw_ready;
  logic       dropped;

  // Environment side: drives camera samples and the pixel-buffer ready
  modport master (
    output cam_x, cam_y, cam_valid, draw_ready,
    input  pen_x, pen_y, pen_down, draw_valid, dropped
  );

  // Tracker side
  modport slave (
    input  cam_x, cam_y, cam_valid, draw_ready,
    output pen_x, pen_y, pen_down, draw_valid, dropped
  );
endinterface

`default_nettype wire

// File: rtl/pen_tracker.sv
// ============================================================================
//  Module   : pen_tracker
//  Purpose  : Debounces IR pen presence, scales 1024x768 camera coordinates
//             to 640x480, box-filters jitter and offers each point to the
//             pixel buffer on a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pen_tracker #(
  parameter int AVG_LOG2    = 2,
  parameter int PRESENT_CNT = 3,
  parameter int ABSENT_CNT  = 4,
  parameter int H_MAX       = 639,
  parameter int V_MAX       = 479
) (
  input  logic          clk,
  input  logic          reset,
  pen_tracker_if.slave  io
);

  localparam int TAPS    = 1 << AVG_LOG2;
  localparam int SW      = 10 + AVG_LOG2;
  localparam int CNT_MAX = (PRESENT_CNT > ABSENT_CNT) ? PRESENT_CNT : ABSENT_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_PRES = CW'(PRESENT_CNT);
  localparam logic [CW-1:0] C_ABS  = CW'(ABSENT_CNT);
  localparam logic [12:0]   C_HMAX = 13'(H_MAX);
  localparam logic [12:0]   C_VMAX = 13'(V_MAX);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMING    = 2'd1,
    S_TRACKING  = 2'd2,
    S_RELEASING = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            feed_d, prime_d;

  logic            s1_valid_q, s1_prime_q;
  logic [9:0]      s1_x_q, s1_y_q;

  logic [9:0]      tap_x_q [TAPS];
  logic [9:0]      tap_y_q [TAPS];
  logic [SW-1:0]   sum_x_q, sum_y_q;
  logic            flt_valid_q;

  logic [9:0]      pen_x_q, pen_y_q;
  logic            draw_valid_q, dropped_q;

  // 1023 on the y channel is the camera's "no blob" code
  logic            w_present;
  logic [CW-1:0]   w_cnt_inc;
  logic [12:0]     w_x13, w_y13, w_sx13, w_sy13;
  logic [9:0]      w_sx, w_sy, w_fx, w_fy;

  assign w_present = (io.cam_y != 10'd1023);
  assign w_cnt_inc = cnt_q + CW'(1);

  // x*5/8 maps 1024 -> 640 and 768 -> 480; 13 bits hold 1023*5
  assign w_x13  = 13'(io.cam_x) * 13'd5;
  assign w_y13  = 13'(io.cam_y) * 13'd5;
  assign w_sx13 = w_x13 >> 3;
  assign w_sy13 = w_y13 >> 3;
  assign w_sx   = (w_sx13 > C_HMAX) ? 10'(C_HMAX) : 10'(w_sx13);
  assign w_sy   = (w_sy13 > C_VMAX) ? 10'(C_VMAX) : 10'(w_sy13);

  // Box-filter average is the running sum divided by the window length
  assign w_fx = 10'(sum_x_q >> AVG_LOG2);
  assign w_fy = 10'(sum_y_q >> AVG_LOG2);

  // Presence FSM state register, advanced only by camera strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Presence debounce: decide next state and whether this sample feeds/primes the filter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    feed_d  = 1'b0;
    prime_d = 1'b0;
    if (io.cam_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (w_present) begin
            if (C_PRES <= CW'(1)) begin
              state_d = S_TRACKING;
              cnt_d   = '0;
              feed_d  = 1'b1;
              prime_d = 1'b1;
            end else begin
              state_d = S_ARMING;
              cnt_d   = CW'(1);
            end
          end
        end
        S_ARMING: begin
          if (!w_present) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (w_cnt_inc >= C_PRES) begin
            state_d = S_TRACKING;
            cnt_d   = '0;
            feed_d  = 1'b1;
            prime_d = 1'b1;
          end else begin
            cnt_d   = w_cnt_inc;
          end
        end
        S_TRACKING: begin
          if (w_present) begin
            feed_d = 1'b1;
          end else if (C_ABS <= CW'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_RELEASING;
            cnt_d   = CW'(1);
          end
        end
        S_RELEASING: begin
          if (w_present) begin
            state_d = S_TRACKING;
            cnt_d   = '0;
            feed_d  = 1'b1;
          end else if (w_cnt_inc >= C_ABS) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = w_cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage 1: capture scaled, clamped coordinates of samples that reach the filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_prime_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= feed_d;
      s1_prime_q <= prime_d;
      if (feed_d) begin
        s1_x_q <= w_sx;
        s1_y_q <= w_sy;
      end
    end
  end

  // Stage 2: moving-average window; a priming sample fills every tap so the first output equals it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        tap_x_q[i] <= '0;
        tap_y_q[i] <= '0;
      end
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      flt_valid_q <= 1'b0;
    end else begin
      flt_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        if (s1_prime_q) begin
          for (int i = 0; i < TAPS; i++) begin
            tap_x_q[i] <= s1_x_q;
            tap_y_q[i] <= s1_y_q;
          end
          sum_x_q <= SW'(s1_x_q) << AVG_LOG2;
          sum_y_q <= SW'(s1_y_q) << AVG_LOG2;
        end else begin
          tap_x_q[0] <= s1_x_q;
          tap_y_q[0] <= s1_y_q;
          for (int i = 1; i < TAPS; i++) begin
            tap_x_q[i] <= tap_x_q[i-1];
            tap_y_q[i] <= tap_y_q[i-1];
          end
          sum_x_q <= sum_x_q + SW'(s1_x_q) - SW'(tap_x_q[TAPS-1]);
          sum_y_q <= sum_y_q + SW'(s1_y_q) - SW'(tap_y_q[TAPS-1]);
        end
      end
    end
  end

  // Stage 3: output holding register; a new point overwrites an unaccepted one and flags the loss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pen_x_q      <= '0;
      pen_y_q      <= '0;
      draw_valid_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else if (flt_valid_q) begin
      pen_x_q      <= w_fx;
      pen_y_q      <= w_fy;
      draw_valid_q <= 1'b1;
      dropped_q    <= draw_valid_q && !io.draw_ready;
    end else begin
      dropped_q <= 1'b0;
      if (draw_valid_q && io.draw_ready) begin
        draw_valid_q <= 1'b0;
      end
    end
  end

  assign io.pen_x      = pen_x_q;
  assign io.pen_y      = pen_y_q;
  assign io.pen_down   = (state_q == S_TRACKING) || (state_q == S_RELEASING);
  assign io.draw_valid = draw_valid_q;
  assign io.dropped    = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_pen_tracker.sv
// ============================================================================
//  Module   : tb_pen_tracker
//  Purpose  : Directed self-checking bench for pen_tracker against a
//             behavioural model of presence runs, window averaging and the
//             draw handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pen_tracker;

  localparam int PRESENT_CNT = 3;
  localparam int ABSENT_CNT  = 4;
  localparam int WIN         = 4;

  logic clk;
  logic reset;
  pen_tracker_if io ();

  pen_tracker #(
    .AVG_LOG2(2), .PRESENT_CNT(PRESENT_CNT), .ABSENT_CNT(ABSENT_CNT),
    .H_MAX(639), .V_MAX(479)
  ) dut (
    .clk(clk), .reset(reset), .io(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int e; int x; int y; } pt_t;
  pt_t q[$];
  pt_t p;
  int  k;
  bit  m_pd, m_dv, m_drop;
  int  m_x, m_y;
  int  pres_run, abs_run;
  int  hx[WIN], hy[WIN];

  function automatic int to_vga(input int v, input int lim);
    int s;
    s = (v * 640) / 1024;
    return (s > lim) ? lim : s;
  endfunction

  task automatic model_clear();
    q.delete();
    k = 0; m_pd = 0; m_dv = 0; m_drop = 0; m_x = 0; m_y = 0;
    pres_run = 0; abs_run = 0;
    for (int i = 0; i < WIN; i++) begin hx[i] = 0; hy[i] = 0; end
  endtask

  task automatic push_avg();
    int sx, sy;
    sx = 0; sy = 0;
    for (int i = 0; i < WIN; i++) begin sx += hx[i]; sy += hy[i]; end
    q.push_back('{k + 2, sx / WIN, sy / WIN});
  endtask

  task automatic model_sample(input int cx, input int cy);
    bit pres;
    int vx, vy;
    pres = (cy != 1023);
    vx = to_vga(cx, 639);
    vy = to_vga(cy, 479);
    if (!m_pd) begin
      if (pres) begin
        pres_run++;
        if (pres_run >= PRESENT_CNT) begin
          m_pd = 1; abs_run = 0;
          for (int i = 0; i < WIN; i++) begin hx[i] = vx; hy[i] = vy; end
          push_avg();
        end
      end else pres_run = 0;
    end else begin
      if (!pres) begin
        abs_run++;
        if (abs_run >= ABSENT_CNT) begin m_pd = 0; pres_run = 0; end
      end else begin
        abs_run = 0;
        for (int i = WIN - 1; i > 0; i--) begin hx[i] = hx[i-1]; hy[i] = hy[i-1]; end
        hx[0] = vx; hy[0] = vy;
        push_avg();
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      if (q.size() > 0 && q[0].e == k) begin
        p = q.pop_front();
        m_drop = m_dv && !io.draw_ready;
        m_dv = 1; m_x = p.x; m_y = p.y;
      end else begin
        m_drop = 0;
        if (m_dv && io.draw_ready) m_dv = 0;
      end
      if (io.cam_valid) model_sample(int'(io.cam_x), int'(io.cam_y));
      k++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (run && !reset) begin
      chk("pen_down",   32'(io.pen_down),   32'(m_pd));
      chk("draw_valid", 32'(io.draw_valid), 32'(m_dv));
      chk("dropped",    32'(io.dropped),    32'(m_drop));
      chk("pen_x",      32'(io.pen_x),      32'(m_x));
      chk("pen_y",      32'(io.pen_y),      32'(m_y));
    end
  end

  // Transfer and drop counters observed on the DUT pins
  int xfers = 0;
  int drops = 0;
  always @(posedge clk) begin
    if (!reset && io.draw_valid && io.draw_ready) xfers++;
    if (!reset && io.dropped) drops++;
  end

  // ---------------- stimulus ----------------
  task automatic sample(input int x, input int y);
    io.cam_x = 10'(x); io.cam_y = 10'(y); io.cam_valid = 1'b1;
    @(negedge clk);
    io.cam_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int x0, d0;

  initial begin
    reset = 1'b1;
    io.cam_x = '0; io.cam_y = '0; io.cam_valid = 1'b0; io.draw_ready = 1'b1;
    idle(3);
    chk("rst_pen_x", 32'(io.pen_x), 0);
    chk("rst_dv",    32'(io.draw_valid), 0);
    chk("rst_pd",    32'(io.pen_down), 0);
    #1 reset = 1'b0;
    run = 1'b1;
    @(negedge clk);

    // Acquire at (512,384) -> (320,240)
    sample(512, 384); sample(512, 384); sample(512, 384);
    chk("s1_pd_rise", 32'(io.pen_down), 1);
    chk("s1_dv_early", 32'(io.draw_valid), 0);
    @(negedge clk);
    chk("s1_dv", 32'(io.draw_valid), 1);
    chk("s1_x",  32'(io.pen_x), 320);
    chk("s1_y",  32'(io.pen_y), 240);
    idle(3);
    chk("s1_xfers", 32'(xfers), 1);

    // Move to x=324: average steps 321..324
    for (int i = 0; i < 4; i++) sample(519, 384);
    idle(2);
    chk("s2_x", 32'(io.pen_x), 324);
    chk("s2_y", 32'(io.pen_y), 240);

    // Three absent then present: pen stays down, absent samples draw nothing
    x0 = xfers;
    for (int i = 0; i < 3; i++) sample(100, 1023);
    idle(3);
    chk("s3_pd_hold", 32'(io.pen_down), 1);
    chk("s3_no_draw", 32'(xfers), 32'(x0));
    sample(519, 384);
    chk("s3_pd_back", 32'(io.pen_down), 1);
    idle(2);
    for (int i = 0; i < 4; i++) sample(100, 1023);
    chk("s3_pd_fall", 32'(io.pen_down), 0);
    sample(519, 384); sample(519, 384);
    chk("s3_arming", 32'(io.pen_down), 0);
    sample(519, 384);
    chk("s3_rearm", 32'(io.pen_down), 1);
    idle(3);

    // Out-of-range present samples clamp
    for (int i = 0; i < 4; i++) sample(100, 1023);
    for (int i = 0; i < 3; i++) sample(1023, 1022);
    idle(2);
    chk("s4_x_clamp", 32'(io.pen_x), 639);
    chk("s4_y_clamp", 32'(io.pen_y), 479);

    // Back-pressure: second point overwrites the first
    io.draw_ready = 1'b0;
    d0 = drops; x0 = xfers;
    sample(519, 384); sample(519, 384);
    idle(3);
    chk("s5_drops", 32'(drops - d0), 1);
    chk("s5_dv",    32'(io.draw_valid), 1);
    chk("s5_x",     32'(io.pen_x), 481);
    chk("s5_y",     32'(io.pen_y), 359);
    io.draw_ready = 1'b1;
    @(negedge clk);
    chk("s5_dv_fall", 32'(io.draw_valid), 0);
    chk("s5_xfer",    32'(xfers - x0), 1);

    // Reset with a point pending and the pen releasing
    io.draw_ready = 1'b0;
    sample(519, 384);
    sample(100, 1023);
    chk("s6_pre_dv", 32'(io.draw_valid), 1);
    chk("s6_pre_pd", 32'(io.pen_down), 1);
    #2 reset = 1'b1;
    #1;
    chk("s6_rst_x",  32'(io.pen_x), 0);
    chk("s6_rst_y",  32'(io.pen_y), 0);
    chk("s6_rst_pd", 32'(io.pen_down), 0);
    chk("s6_rst_dv", 32'(io.draw_valid), 0);
    chk("s6_rst_dr", 32'(io.dropped), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    io.draw_ready = 1'b1;
    sample(512, 384); sample(512, 384);
    chk("s6_no_pd", 32'(io.pen_down), 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pen_tracker.md
Name: pen_tracker

Overview:
Conditions the raw blob coordinates produced by the IR camera poller before they reach the pixel buffer.
- Rejects the "no blob" code and debounces pen presence.
- Scales camera space (1024x768) to VGA space (640x480).
- Box-filters jitter.
- Offers each filtered point to the pixel buffer on a valid/ready handshake.

Sits between camera (upstream, I2C-polled x/y) and pixel_buffer (downstream, SRAM writer).

Parameters:
AVG_LOG2, 2, log2 of moving-average window (window = 4 samples); legal 0..3
PRESENT_CNT, 3, consecutive present samples required to assert pen_down
ABSENT_CNT, 4, consecutive absent samples required to drop pen_down
H_MAX, 639, clamp limit for scaled x
V_MAX, 479, clamp limit for scaled y

Ports:
clk  in  1  single system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
cam_x  in  10  raw camera x, 0..1023
cam_y  in  10  raw camera y, 0..767; 1023 = no blob
cam_valid  in  1  one-cycle strobe, cam_x/cam_y valid this cycle
pen_x  out  10  filtered VGA x, 0..H_MAX
pen_y  out  10  filtered VGA y, 0..V_MAX
pen_down  out  1  debounced pen-present flag
draw_valid  out  1  pen_x/pen_y hold a point for the pixel buffer
draw_ready  in  1  pixel buffer accepts point when high with draw_valid
dropped  out  1  one-cycle pulse when an unaccepted point is overwritten

Behaviour:
- Reset (async, active-high): pen_x=0, pen_y=0, pen_down=0, draw_valid=0, dropped=0, FSM=IDLE, counters=0, filter taps=0.
- Sample classification on cam_valid:
  - present when cam_y != 1023; absent otherwise.
  - Cycles without cam_valid change nothing except handshake completion.
- Scaling, stage 1 (registered, cycle n+1 after cam_valid at n):
  - sx = (cam_x*5)>>3; sy = (cam_y*5)>>3, using 13-bit intermediates.
  - Clamp sx to H_MAX and sy to V_MAX.
  - Examples: 1023 -> 639; cam_y 767 -> 479.
- FSM (advances only on cam_valid):
  - IDLE: present -> ARMING, cnt=1. Absent stays in IDLE.
  - ARMING: present -> cnt+1; on reaching PRESENT_CNT -> TRACKING, pen_down=1. Absent -> IDLE, cnt=0.
  - TRACKING: absent -> RELEASING, cnt=1. Present -> stays, feeds filter.
  - RELEASING: absent -> cnt+1; on reaching ABSENT_CNT -> IDLE, pen_down=0. Present -> TRACKING, feeds filter. Filter is not re-primed.
  - Absent samples never enter the filter.
- Filter, stage 2 (cycle n+2):
  - Shift register of 2^AVG_LOG2 taps, each 10 bits, plus a running sum of (10+AVG_LOG2) bits.
  - sum <= sum + new - oldest. Output = sum >> AVG_LOG2 (truncate).
  - The sample that causes ARMING -> TRACKING primes all taps with its value and sets sum = value << AVG_LOG2. The first output therefore equals that sample exactly.
- Output, stage 3 (cycle n+3):
  - Each filter output registers into pen_x/pen_y and sets draw_valid=1.
  - Minimum latency cam_valid -> draw_valid is 3 cycles.
- Handshake:
  - Point transfers on the cycle where draw_valid && draw_ready. draw_valid clears the next cycle unless a new point loads on that same cycle.
  - pen_x/pen_y stable while draw_valid && !draw_ready.
  - New point arriving while draw_valid && !draw_ready: overwrite pen_x/pen_y, keep draw_valid=1, pulse dropped for 1 cycle.
  - New point arriving the same cycle as acceptance: new point loads, draw_valid stays 1, no dropped pulse.
- pen_down falling (to IDLE) does not cancel a pending draw_valid; the last point still delivers.
- Reset mid-operation: immediate async clear of all state and outputs, including a pending point.

Test Plan:
- Reset, then cam_valid pulses with (512,384) x3 and draw_ready=1 -> pen_down rises after 3rd sample; pen_x=320, pen_y=240 with draw_valid 3 cycles after 3rd strobe; exactly one point delivered for the 3rd sample.
- Tracking at (320,240), then samples scaling to 324,324,324,324 -> outputs 321,322,323,324 (x); y unchanged at 240.
- Tracking, then cam_y=1023 x3 followed by a present sample -> pen_down stays 1, no draw_valid for the absent samples. Repeat with x4 absent -> pen_down falls on 4th; the next present sample starts ARMING.
- cam_x=1023, cam_y=1022 (present, out of range) x3 -> pen_x=639, pen_y=479.
- draw_ready=0 while two points are produced -> dropped pulses once; pen_x/pen_y hold the second point; raising draw_ready transfers it and draw_valid falls the next cycle.
- Assert reset while draw_valid=1 and the FSM is in RELEASING -> all outputs 0 in the same cycle; after release, 2 present samples give no pen_down.
